// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave. Deserializes MSB-first frames from the master into rx_data
// (valid/ready handshake) while shifting a response word captured at frame start out on
// master_data. Reports aborted frames (frame_err) and dropped words (overrun).
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   spi_cs, spi_clk   chip select (active low) and serial clock (idle low) from the master
//   spi_data          serial data from the master (MOSI)
//   master_data       serial data to the master (MISO)
//   tx_data           response word, captured on the chip-select falling edge
//   rx_data/rx_valid  last complete received word and its valid flag; rx_ready consumes it
//   bit_count         bits received in the current frame
//   frame_err         one-cycle pulse when CS rises before WIDTH bits
//   overrun           one-cycle pulse when a completed word is dropped
//
// Build option: define SPI_SYNC_EN to pass the SPI pins through 2-flop synchronizers
// (master in an unrelated clock domain, spi_clk <= clk/4). Otherwise the pins are sampled
// directly and compared against a single registered copy.
module spi_slave_rx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             spi_clk,
  input  logic             spi_data,
  output logic             master_data,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StWaitCs} state_e;

  logic cs_cur, sclk_cur, data_cur;
  logic cs_prev_q, sclk_prev_q;

`ifdef SPI_SYNC_EN
  logic [1:0] cs_sync_q, sclk_sync_q, data_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      data_sync_q <= 2'b00;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      data_sync_q <= {data_sync_q[0], spi_data};
      cs_prev_q   <= cs_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign cs_cur   = cs_sync_q[1];
  assign sclk_cur = sclk_sync_q[1];
  assign data_cur = data_sync_q[1];
`else
  // cs_prev resets low so a CS already held low at reset release never looks like a fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_prev_q   <= spi_cs;
      sclk_prev_q <= spi_clk;
    end
  end

  assign cs_cur   = spi_cs;
  assign sclk_cur = spi_clk;
  assign data_cur = spi_data;
`endif

  logic cs_fall, sclk_rise, sclk_fall;
  assign cs_fall   = cs_prev_q & ~cs_cur;
  assign sclk_rise = ~sclk_prev_q & sclk_cur;
  assign sclk_fall = sclk_prev_q & ~sclk_cur;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             master_data_q, master_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    bit_count_d   = bit_count_q;
    master_data_d = master_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        master_data_d = 1'b0;
        // A coincident clock rise is dropped: the first sampled rise is seen in StShift.
        if (cs_fall) begin
          tx_d          = tx_data;
          master_data_d = tx_data[WIDTH-1];
          rx_shift_d    = '0;
          bit_count_d   = '0;
          state_d       = StShift;
        end
      end
      StShift: begin
        // bit_count is always below WIDTH here, so any CS deassert is an abort.
        if (cs_cur) begin
          frame_err_d   = 1'b1;
          rx_shift_d    = '0;
          bit_count_d   = '0;
          master_data_d = 1'b0;
          state_d       = StIdle;
        end else if (sclk_rise) begin
          rx_shift_d  = {rx_shift_q[WIDTH-2:0], data_cur};
          bit_count_d = bit_count_q + CNT_W'(1);
          if (bit_count_q == CNT_W'(WIDTH - 1)) begin
            state_d = StDone;
          end
        end else if (sclk_fall) begin
          tx_d          = tx_q << 1;
          master_data_d = tx_q[WIDTH-2];
        end
      end
      StDone: begin
        master_data_d = 1'b0;
        if (rx_valid_q && !rx_ready) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end
        state_d = StWaitCs;
      end
      StWaitCs: begin
        master_data_d = 1'b0;
        // Level test, so a CS deassert that landed during StDone is still honoured.
        if (cs_cur) begin
          bit_count_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      tx_q          <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_count_q   <= '0;
      master_data_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      bit_count_q   <= bit_count_d;
      master_data_q <= master_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign master_data = master_data_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign bit_count   = bit_count_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: a behavioural SPI master drives frames while a frame-level
// model predicts rx_data, rx_valid, pulse counts and the word the master reads back.
module tb_spi_slave_rx;

  localparam int HALF = 4;  // spi_clk half period in clk cycles
`ifdef SPI_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spi_cs = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_data = 1'b0;
  logic        rx_ready = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        master_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [4:0]  bit_count;
  logic        frame_err;
  logic        overrun;

  spi_slave_rx #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs      (spi_cs),
    .spi_clk     (spi_clk),
    .spi_data    (spi_data),
    .master_data (master_data),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .bit_count   (bit_count),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed pulse counts.
  int   ovr_cnt = 0;
  int   ferr_cnt = 0;
  int   pulse_cnt = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid && !valid_prev) pulse_cnt <= pulse_cnt + 1;
    valid_prev <= rx_valid;
  end

  // Frame-level reference model.
  logic [15:0] m_data = 16'h0;
  logic        m_valid = 1'b0;
  int          m_ovr = 0;
  int          m_ferr = 0;
  int          m_pulses = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Assert CS, then clock nbits MSB-first. Samples MISO as each rising edge is driven.
  task automatic spi_bits(input logic [15:0] word, input int nbits, input bit timing,
                          output logic [15:0] cap);
    cap = 16'h0;
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_data = word[15-i];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      cap[15-i] = master_data;
      if (timing && i == 15) begin
        @(posedge clk);  // T: first edge sampling the last rise
        repeat (LAT - 1) @(posedge clk);
        #1 check("rx_valid_before_latency", 32'(rx_valid), 32'd0);
        @(posedge clk);
        #1 check("rx_valid_at_latency", 32'(rx_valid), 32'd1);
        @(posedge clk);
        #1 check("rx_valid_single_pulse", 32'(rx_valid), 32'd0);
        @(negedge clk);
      end
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap);
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic full_frame(input logic [15:0] word, input logic [15:0] tx, input int gap);
    logic [15:0] cap;
    tx_data = tx;
    if (rx_ready) m_valid = 1'b0;
    spi_bits(word, 16, rx_ready, cap);
    check("bit_count_full", 32'(bit_count), 32'd16);
    check("miso_word", 32'(cap), 32'(tx));
    if (m_valid && !rx_ready) begin
      m_ovr++;
    end else begin
      if (!m_valid) m_pulses++;
      m_data  = word;
      m_valid = 1'b1;
    end
    if (rx_ready) m_valid = 1'b0;
    end_frame(gap);
  endtask

  task automatic check_state();
    check("rx_data", 32'(rx_data), 32'(m_data));
    check("rx_valid", 32'(rx_valid), 32'(m_valid));
    check("overrun_pulses", 32'(ovr_cnt), 32'(m_ovr));
    check("frame_err_pulses", 32'(ferr_cnt), 32'(m_ferr));
    check("rx_valid_pulses", 32'(pulse_cnt), 32'(m_pulses));
    check("bit_count_idle", 32'(bit_count), 32'd0);
    check("master_data_idle", 32'(master_data), 32'd0);
  endtask

  task automatic check_all_zero();
    check("rst_master_data", 32'(master_data), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cap;
    logic [15:0] w;
    logic [15:0] t;

    // Reset state, CS held low throughout.
    repeat (3) @(negedge clk);
    #1 check_all_zero();

    // CS already low at release: clocks must be ignored until a genuine fall.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    spi_data = 1'b1;
    repeat (5) begin
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    check("cs_low_at_release_bit_count", 32'(bit_count), 32'd0);
    check("cs_low_at_release_rx_valid", 32'(rx_valid), 32'd0);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame.
    rx_ready = 1'b1;
    full_frame(16'hA569, 16'h3425, 4);
    check_state();

    // Back-to-back frames with a single clk of CS high.
    full_frame(16'h2563, 16'h0001, 1);
    full_frame(16'h9B63, 16'hA569, 4);
    check_state();

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    full_frame(16'h6A61, 16'h1234, 4);
    check_state();
    full_frame(16'h9B22, 16'h5678, 4);
    check_state();
    rx_ready = 1'b1;
    m_valid  = 1'b0;
    @(negedge clk);
    check("rx_valid_after_consume", 32'(rx_valid), 32'd0);

    // Aborted frame after 9 bits.
    spi_bits(16'hA569, 9, 1'b0, cap);
    check("bit_count_partial", 32'(bit_count), 32'd9);
    end_frame(4);
    m_ferr++;
    check_state();
    full_frame(16'h3425, 16'hC3C3, 4);
    check_state();

    // Asynchronous reset in the middle of a frame.
    spi_bits(16'hA569, 7, 1'b0, cap);
    reset = 1'b0;
    #1 check_all_zero();
    m_data  = 16'h0;
    m_valid = 1'b0;
    spi_cs  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_state();
    full_frame(16'h0001, 16'h8001, 4);
    check_state();

    // Randomized frames with random consumer readiness.
    repeat (20) begin
      rx_ready = 1'($urandom_range(0, 1));
      w = 16'($urandom);
      t = 16'($urandom);
      full_frame(w, t, 4);
      check_state();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
